wr_stream_adapter: RTL and testbench

- Write-side front end of the asynchronous FIFO, in the wclk domain, directly upstream of the write pointer/full controller.
- Converts a valid/ready producer stream into the controller's single-strobe wen/wdata interface.
- A 2-entry skid buffer absorbs the controller's registered-wfull lag.
- Computes local occupancy from the write pointer and the synchronized read pointer; counts stall cycles.

---
 rtl/wr_stream_adapter.sv | 112 +++++++++++
 tb/tb_wr_stream_adapter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_stream_adapter.sv
// Write-side stream front end of the async FIFO: valid/ready to wen/wdata through a 2-entry skid buffer.
// Optional almost-full throttling is built when WR_AFULL_EN is defined; otherwise wafull is tied low.
module wr_stream_adapter #(
   parameter int DATA_W       = 8,
   parameter int PTR_W        = 6,
   parameter int DEPTH        = 32,
   parameter int AFULL_THRESH = 28
) (
   input  logic              wclk,
   input  logic              wrst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              wen,
   output logic [DATA_W-1:0] wdata,
   input  logic              wfull,
   input  logic [PTR_W-1:0]  wptr,
   input  logic [PTR_W-1:0]  rptr_wclk,
   output logic              wafull,
   output logic [15:0]       stall_cnt
);

   // State encoding doubles as the number of buffered entries.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic [15:0]       r_stall_cnt;
   logic [PTR_W-1:0]  w_occ;
   logic              w_full_eff;
   logic              w_room;
   logic              w_push;
   logic              w_pop;

   // Modular subtract handles wrap of both pointers.
   assign w_occ      = wptr - rptr_wclk;
   assign w_full_eff = wfull | (w_occ >= PTR_W'(DEPTH));

`ifdef WR_AFULL_EN
   logic [PTR_W:0] w_afull_level;
   logic           r_wafull;

   assign w_afull_level = (PTR_W+1)'(w_occ) + (PTR_W+1)'(r_state);

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_wafull <= 1'b0;
      end else begin
         r_wafull <= (w_afull_level >= (PTR_W+1)'(AFULL_THRESH));
      end
   end

   assign wafull = r_wafull;
   assign w_room = (r_state != ST_TWO) & ~r_wafull;
`else
   assign wafull = 1'b0;
   assign w_room = (r_state != ST_TWO);
`endif

   assign s_ready   = wrst_n & w_room;
   assign wen       = wrst_n & (r_state != ST_EMPTY) & ~w_full_eff;
   assign wdata     = r_head;
   assign stall_cnt = r_stall_cnt;
   assign w_push    = s_valid & s_ready;
   assign w_pop     = wen;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_push) w_state_next = ST_ONE;
         ST_ONE: begin
            if (w_push & ~w_pop)      w_state_next = ST_TWO;
            else if (w_pop & ~w_push) w_state_next = ST_EMPTY;
         end
         ST_TWO:   if (w_pop) w_state_next = ST_ONE;
         default:  w_state_next = ST_EMPTY;
      endcase
   end

   // Head holds its last value when the buffer drains, so wdata is stable while idle.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_state <= ST_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_EMPTY: if (w_push) r_head <= s_data;
            ST_ONE: begin
               if (w_push & w_pop) r_head <= s_data;
               else if (w_push)    r_tail <= s_data;
            end
            ST_TWO:   if (w_pop) r_head <= r_tail;
            default: ;
         endcase
      end
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_stall_cnt <= '0;
      end else if ((r_state != ST_EMPTY) && w_full_eff && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_wr_stream_adapter.sv
// Directed bench for wr_stream_adapter; the almost-full section follows WR_AFULL_EN.
module tb_wr_stream_adapter;
   localparam int DATA_W = 8;
   localparam int PTR_W  = 6;

   logic              wclk = 1'b0;
   logic              wrst_n;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              wen;
   logic [DATA_W-1:0] wdata;
   logic              wfull;
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr_wclk;
   logic              wafull;
   logic [15:0]       stall_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_stall = 0;
   int n_acc;
   logic [DATA_W-1:0] exp_q[$];

   always #5 wclk = ~wclk;

   wr_stream_adapter #(.DATA_W(DATA_W), .PTR_W(PTR_W), .DEPTH(32), .AFULL_THRESH(28)) u_dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .wen       (wen),
      .wdata     (wdata),
      .wfull     (wfull),
      .wptr      (wptr),
      .rptr_wclk (rptr_wclk),
      .wafull    (wafull),
      .stall_cnt (stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic smp();
      @(negedge wclk);
   endtask

   initial begin
      wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0; wptr = '0; rptr_wclk = '0;

      // Reset
      step(); step();
      smp();
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_wen", 32'(wen), 0);
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_wafull", 32'(wafull), 0);
      step();
      wrst_n = 1'b1;
      smp();
      chk("rel_ready", 32'(s_ready), 1);
      step();

      // Stream 10 beats back to back
      for (int k = 0; k < 12; k++) begin
         s_valid = (k < 10);
         s_data  = 8'(k + 1);
         smp();
         chk("t1_ready", 32'(s_ready), 1);
         chk("t1_wen", 32'(wen), (k >= 1 && k <= 10) ? 1 : 0);
         if (k >= 1 && k <= 10) begin
            chk("t1_wdata", 32'(wdata), k);
            $display("t1 beat wdata=0x%02h", wdata);
         end
         step();
      end
      chk("t1_stall", 32'(stall_cnt), 0);

`ifndef WR_AFULL_EN
      // Occupancy at capacity blocks writes before wfull rises
      wptr = 6'd32; rptr_wclk = 6'd0; s_valid = 1'b1; s_data = 8'hA1;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) s_data = 8'hA2;
         if (c >= 2) s_data = 8'hA3;
         smp();
         chk("t2_ready", 32'(s_ready), (c < 2) ? 1 : 0);
         chk("t2_wen", 32'(wen), 0);
         chk("t2_stall", 32'(stall_cnt), (c == 0) ? 0 : c - 1);
         step();
      end
      rptr_wclk = 6'd1;
      smp();
      chk("t2_rel_wen", 32'(wen), 1);
      chk("t2_rel_wdata", 32'(wdata), 32'h A1);
      chk("t2_rel_ready", 32'(s_ready), 0);
      chk("t2_rel_stall", 32'(stall_cnt), 4);
      step();
      smp();
      chk("t2_ready_back", 32'(s_ready), 1);
      chk("t2_wdata2", 32'(wdata), 32'h A2);
      step();
      s_valid = 1'b0;
      smp();
      chk("t2_wen3", 32'(wen), 1);
      chk("t2_wdata3", 32'(wdata), 32'h A3);
      step();
      smp();
      chk("t2_idle", 32'(wen), 0);
      step();
      exp_stall = 4;
`endif

      // Wrapped pointers: occ = 3 - 61 mod 64 = 6
      wptr = 6'd3; rptr_wclk = 6'd61;
      for (int k = 0; k < 5; k++) begin
         s_valid = (k < 3);
         s_data  = 8'(8'hB1 + k);
         smp();
         chk("t3_wen", 32'(wen), (k >= 1 && k <= 3) ? 1 : 0);
         if (k >= 1 && k <= 3) chk("t3_wdata", 32'(wdata), 32'h B0 + k);
         step();
      end
      chk("t3_stall", 32'(stall_cnt), exp_stall);

`ifndef WR_AFULL_EN
      // wfull falling while two entries are held: wen in that same cycle
      wfull = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
      smp(); chk("t3b_wen0", 32'(wen), 0); step();
      s_data = 8'hC2;
      smp(); chk("t3b_ready1", 32'(s_ready), 1); chk("t3b_wen1", 32'(wen), 0); step();
      s_valid = 1'b0;
      smp();
      chk("t3b_ready2", 32'(s_ready), 0);
      chk("t3b_stall2", 32'(stall_cnt), exp_stall + 1);
      step();
      wfull = 1'b0;
      smp();
      chk("t3b_wen_fall", 32'(wen), 1);
      chk("t3b_wdata_fall", 32'(wdata), 32'h C1);
      chk("t3b_stall3", 32'(stall_cnt), exp_stall + 2);
      step();
      smp(); chk("t3b_wdata2", 32'(wdata), 32'h C2); step();
      smp(); chk("t3b_idle", 32'(wen), 0); step();
      exp_stall = exp_stall + 2;
`endif

      // Alternating valid with occasional wfull, scoreboarded
      wptr = '0; rptr_wclk = '0; n_acc = 0;
      for (int i = 0; i < 25; i++) begin
         s_valid = (i < 20) && (i % 2 == 0);
         s_data  = 8'(8'h40 + i);
         wfull   = (i < 20) && (i % 7 == 5);
         smp();
         if (wen) begin
            if (exp_q.size() == 0) chk("t4_underflow", 1, 0);
            else chk("t4_wdata", 32'(wdata), 32'(exp_q.pop_front()));
            $display("t4 beat wdata=0x%02h", wdata);
         end
         if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            n_acc++;
         end
         step();
      end
      chk("t4_left", exp_q.size(), 0);
      chk("t4_accepts", n_acc, 10);
      exp_stall = exp_stall + 2;
      chk("t4_stall", 32'(stall_cnt), exp_stall);

      // Reset while two entries are buffered
      wfull = 1'b1; s_valid = 1'b1; s_data = 8'hD1;
      smp(); step();
      s_data = 8'hD2;
      smp(); step();
      s_valid = 1'b0;
      smp(); chk("t5_full_ready", 32'(s_ready), 0); step();
      wrst_n = 1'b0;
      smp();
      chk("t5_rst_ready", 32'(s_ready), 0);
      chk("t5_rst_wen", 32'(wen), 0);
      step();
      wrst_n = 1'b1; wfull = 1'b0;
      smp();
      chk("t5_wen", 32'(wen), 0);
      chk("t5_ready", 32'(s_ready), 1);
      chk("t5_stall", 32'(stall_cnt), 0);
      chk("t5_wafull", 32'(wafull), 0);
      step();
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("t5_no_beat", 32'(wen), 0);
         chk("t5_wdata_clr", 32'(wdata), 0);
         step();
      end

`ifdef WR_AFULL_EN
      // occ=27 plus one buffered beat reaches the threshold
      wptr = 6'd27; rptr_wclk = 6'd0; s_valid = 1'b1; s_data = 8'hE1;
      smp(); chk("t6_wafull0", 32'(wafull), 0); chk("t6_ready0", 32'(s_ready), 1); step();
      s_valid = 1'b0;
      smp(); chk("t6_wen1", 32'(wen), 1); chk("t6_wdata1", 32'(wdata), 32'h E1);
      chk("t6_wafull1", 32'(wafull), 0); step();
      wptr = 6'd28; s_valid = 1'b1; s_data = 8'hE2;
      for (int c = 0; c < 2; c++) begin
         smp();
         chk("t6_wafull_set", 32'(wafull), 1);
         chk("t6_ready_blk", 32'(s_ready), 0);
         chk("t6_wen_blk", 32'(wen), 0);
         step();
      end
      rptr_wclk = 6'd1;
      smp(); chk("t6_wafull_lag", 32'(wafull), 1); chk("t6_ready_lag", 32'(s_ready), 0); step();
      smp(); chk("t6_wafull_clr", 32'(wafull), 0); chk("t6_ready_back", 32'(s_ready), 1); step();
      s_valid = 1'b0;
      smp(); chk("t6_wen2", 32'(wen), 1); chk("t6_wdata2", 32'(wdata), 32'h E2); step();
`else
      // Without the feature wafull stays low even near capacity
      wptr = 6'd31; rptr_wclk = 6'd0; s_valid = 1'b1; s_data = 8'hE1;
      smp(); step();
      s_valid = 1'b0;
      smp();
      chk("t6_wafull_off", 32'(wafull), 0);
      chk("t6_ready_off", 32'(s_ready), 1);
      chk("t6_wen_off", 32'(wen), 1);
      step();
      smp(); chk("t6_wafull_off2", 32'(wafull), 0); step();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
